// File: rtl/button_mode_select.sv
// Push-button mode selector: a short press steps the filter mode index with wrap-around,
// and a long press returns it to the bypass mode.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_IDLE    | button released, hold counter cleared, waiting for a rising edge
// S_PRESSED | button held, counting toward the long-press limit
// S_HELD    | long press already reported, waiting for release
module button_mode_select #(
    parameter int CLOCK_FREQ    = 50000000,
    parameter int LONG_PRESS_MS = 1000,
    parameter int NUM_MODES     = 4,
    parameter int MODE_W        = 2,
    parameter int INIT_MODE     = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              btn_i,
    output logic [MODE_W-1:0] mode_o,
    output logic              mode_changed_o,
    output logic              short_press_o,
    output logic              long_press_o,
    output logic              pressed_o
);

    localparam logic [31:0]       LONG_LIM  = 32'((CLOCK_FREQ / 1000) * LONG_PRESS_MS);
    localparam logic [31:0]       LONG_LAST = LONG_LIM - 32'd1;
    localparam logic [MODE_W-1:0] MODE_LAST = MODE_W'(NUM_MODES - 1);
    localparam logic [MODE_W-1:0] MODE_INIT = MODE_W'(INIT_MODE);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PRESSED = 2'd1,
        S_HELD    = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [31:0]       r_cnt;
    logic [31:0]       w_cnt_nxt;
    logic              r_btn_q;
    logic              w_rise;
    logic [MODE_W-1:0] r_mode;
    logic [MODE_W-1:0] w_mode_nxt;
    logic              r_short;
    logic              r_long;
    logic              r_chg;
    logic              w_short_nxt;
    logic              w_long_nxt;
    logic              w_chg_nxt;

    // btn_q resets high so a button held through reset is not mistaken for a new press.
    assign w_rise = btn_i & ~r_btn_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_btn_q <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_btn_q <= btn_i;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (w_rise) w_state_nxt = S_PRESSED;
            end
            S_PRESSED: begin
                if (!btn_i) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 32'd1;
                    if (r_cnt == LONG_LAST) w_state_nxt = S_HELD;
                end
            end
            S_HELD: begin
                if (!btn_i) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Release is tested first so a release on the limit cycle counts as a short press.
    always_comb begin
        w_mode_nxt  = r_mode;
        w_short_nxt = 1'b0;
        w_long_nxt  = 1'b0;
        w_chg_nxt   = 1'b0;
        if (r_state == S_PRESSED) begin
            if (!btn_i) begin
                w_short_nxt = 1'b1;
                w_chg_nxt   = 1'b1;
                w_mode_nxt  = (r_mode == MODE_LAST) ? '0 : r_mode + MODE_W'(1);
            end else if (r_cnt == LONG_LAST) begin
                w_long_nxt = 1'b1;
                w_chg_nxt  = (r_mode != MODE_INIT);
                w_mode_nxt = MODE_INIT;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode  <= MODE_INIT;
            r_short <= 1'b0;
            r_long  <= 1'b0;
            r_chg   <= 1'b0;
        end else begin
            r_mode  <= w_mode_nxt;
            r_short <= w_short_nxt;
            r_long  <= w_long_nxt;
            r_chg   <= w_chg_nxt;
        end
    end

    assign mode_o         = r_mode;
    assign mode_changed_o = r_chg;
    assign short_press_o  = r_short;
    assign long_press_o   = r_long;
    assign pressed_o      = (r_state != S_IDLE);

endmodule

// File: tb/tb_button_mode_select.sv
// Directed bench for button_mode_select with LONG_LIM = 10 and three modes.
// Every output is sampled 1 time unit after the rising clock edge.
module tb_button_mode_select;

    logic       clk;
    logic       rst;
    logic       btn_i;
    logic [1:0] mode_o;
    logic       mode_changed_o;
    logic       short_press_o;
    logic       long_press_o;
    logic       pressed_o;

    int n_total = 0;
    int n_pass  = 0;

    button_mode_select #(
        .CLOCK_FREQ   (1000),
        .LONG_PRESS_MS(10),
        .NUM_MODES    (3),
        .MODE_W       (2),
        .INIT_MODE    (0)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .btn_i         (btn_i),
        .mode_o        (mode_o),
        .mode_changed_o(mode_changed_o),
        .short_press_o (short_press_o),
        .long_press_o  (long_press_o),
        .pressed_o     (pressed_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Fields are {mode, changed, short, long, pressed}.
    task automatic chk(input string tag, input logic [1:0] m, input logic c,
                       input logic s, input logic l, input logic p);
        logic [5:0] obs;
        logic [5:0] exp;
        obs = {mode_o, mode_changed_o, short_press_o, long_press_o, pressed_o};
        exp = {m, c, s, l, p};
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s at %0t: observed {mode,chg,short,long,pressed}=%b required %b",
                    tag, $time, obs, exp);
    endtask

    task automatic do_short(input logic [1:0] m0, input logic [1:0] m1);
        btn_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("short_hold", m0, 0, 0, 0, 1);
        end
        btn_i = 1'b0;
        tick();
        chk("short_pulse", m1, 1, 1, 0, 0);
        tick();
        chk("short_after", m1, 0, 0, 0, 0);
    endtask

    task automatic do_long(input logic [1:0] m0, input logic exp_chg);
        btn_i = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            chk("long_count", m0, 0, 0, 0, 1);
        end
        tick();
        chk("long_pulse", 2'd0, exp_chg, 0, 1, 1);
        for (int i = 12; i <= 15; i++) begin
            tick();
            chk("long_held", 2'd0, 0, 0, 0, 1);
        end
        btn_i = 1'b0;
        tick();
        chk("long_release", 2'd0, 0, 0, 0, 0);
        tick();
        chk("long_release2", 2'd0, 0, 0, 0, 0);
    endtask

    initial begin
        rst   = 1'b1;
        btn_i = 1'b0;
        #1;
        chk("reset_async", 2'd0, 0, 0, 0, 0);
        tick();
        tick();
        chk("reset_state", 2'd0, 0, 0, 0, 0);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("idle", 2'd0, 0, 0, 0, 0);
        end

        do_short(2'd0, 2'd1);
        do_short(2'd1, 2'd2);
        do_short(2'd2, 2'd0);

        do_short(2'd0, 2'd1);
        do_short(2'd1, 2'd2);
        do_long(2'd2, 1'b1);
        do_long(2'd0, 1'b0);

        // Release lands on the cycle the counter reaches 9: short press must win.
        btn_i = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            chk("tie_count", 2'd0, 0, 0, 0, 1);
        end
        btn_i = 1'b0;
        tick();
        chk("tie_pulse", 2'd1, 1, 1, 0, 0);
        tick();
        chk("tie_after", 2'd1, 0, 0, 0, 0);

        // Single-cycle press.
        btn_i = 1'b1;
        tick();
        chk("one_cycle_hold", 2'd1, 0, 0, 0, 1);
        btn_i = 1'b0;
        tick();
        chk("one_cycle_pulse", 2'd2, 1, 1, 0, 0);
        tick();
        chk("one_cycle_after", 2'd2, 0, 0, 0, 0);

        // Reset in the middle of a hold, button kept high across reset release.
        btn_i = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk("rst_mid_hold", 2'd2, 0, 0, 0, 1);
        end
        rst = 1'b1;
        #1;
        chk("rst_mid_async", 2'd0, 0, 0, 0, 0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            chk("rst_btn_stuck", 2'd0, 0, 0, 0, 0);
        end
        btn_i = 1'b0;
        tick();
        chk("rst_btn_low", 2'd0, 0, 0, 0, 0);
        do_short(2'd0, 2'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
